shift_arbiter: RTL and testbench

//   Shares the single 32-bit shifter datapath between two requesters (port 0: ALU

---
 rtl/shift_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_shift_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 32-bit shifter between two requesters; grant counters enabled by SHIFT_ARB_CNT_EN
module shifter (
   input  logic [31:0] a_i,
   input  logic [4:0]  shamt_i,
   input  logic        drxn_i,
   input  logic        type_i,
   output logic [31:0] y_o
);
   logic signed [31:0] sra;
   // arithmetic left has no meaning here, so it passes the operand through untouched
   always_comb begin
      sra = $signed(a_i) >>> shamt_i;
      y_o = !drxn_i ? (type_i ? a_i : a_i << shamt_i) : (type_i ? sra : a_i >> shamt_i);
   end
endmodule

module shift_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [4:0]       req0_shamt,
   input  logic             req0_drxn,
   input  logic             req0_type,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [4:0]       req1_shamt,
   input  logic             req1_drxn,
   input  logic             req1_type,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_port,
   output logic [TAG_W-1:0] res_tag,
`ifdef SHIFT_ARB_CNT_EN
   output logic             busy,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
`else
   output logic             busy
`endif
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   if (CNT_W < 1 || TAG_W < 1) begin : g_bad_cfg
      $error("shift_arbiter: CNT_W and TAG_W must be at least 1");
   end

   state_t           state_q, state_d;
   logic [31:0]      a_q, a_d;
   logic [4:0]       shamt_q, shamt_d;
   logic             drxn_q, drxn_d;
   logic             type_q, type_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             port_q, port_d;
   logic             last_gnt_q, last_gnt_d;
   logic             res_valid_q, res_valid_d;
   logic [31:0]      res_data_q, res_data_d;
   logic             res_port_q, res_port_d;
   logic [TAG_W-1:0] res_tag_q, res_tag_d;
   logic             gnt0, gnt1, accept;
   logic [31:0]      shift_y;

   shifter u_shifter (
      .a_i    (a_q),
      .shamt_i(shamt_q),
      .drxn_i (drxn_q),
      .type_i (type_q),
      .y_o    (shift_y)
   );

   // a lone requester wins; on a tie the port that did not win last time goes
   always_comb begin
      gnt0       = req0_valid & (!req1_valid | last_gnt_q);
      gnt1       = req1_valid & (!req0_valid | !last_gnt_q);
      req0_ready = (state_q == IDLE) & gnt0;
      req1_ready = (state_q == IDLE) & gnt1;
      accept     = req0_ready | req1_ready;
   end

   // next state: latch the winner in IDLE, shift in EXEC, hold the result in RESP until taken
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      shamt_d     = shamt_q;
      drxn_d      = drxn_q;
      type_d      = type_q;
      tag_d       = tag_q;
      port_d      = port_q;
      last_gnt_d  = last_gnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_port_d  = res_port_q;
      res_tag_d   = res_tag_q;
      case (state_q)
         IDLE: if (accept) begin
            port_d     = req1_ready;
            a_d        = req1_ready ? req1_a : req0_a;
            shamt_d    = req1_ready ? req1_shamt : req0_shamt;
            drxn_d     = req1_ready ? req1_drxn : req0_drxn;
            type_d     = req1_ready ? req1_type : req0_type;
            tag_d      = req1_ready ? req1_tag : req0_tag;
            last_gnt_d = req1_ready;
            state_d    = EXEC;
         end
         EXEC: begin
            res_data_d  = shift_y;
            res_port_d  = port_q;
            res_tag_d   = tag_q;
            res_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; a low rst_n drops any request in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         shamt_q     <= '0;
         drxn_q      <= 1'b0;
         type_q      <= 1'b0;
         tag_q       <= '0;
         port_q      <= 1'b0;
         last_gnt_q  <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_port_q  <= 1'b0;
         res_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         shamt_q     <= shamt_d;
         drxn_q      <= drxn_d;
         type_q      <= type_d;
         tag_q       <= tag_d;
         port_q      <= port_d;
         last_gnt_q  <= last_gnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_port_q  <= res_port_d;
         res_tag_q   <= res_tag_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_port  = res_port_q;
   assign res_tag   = res_tag_q;
   assign busy      = state_q != IDLE;

`ifdef SHIFT_ARB_CNT_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // per-port accept counters wrap naturally; clear beats a same-cycle increment
   always_comb begin
      cnt0_d = cnt_clr ? '0 : cnt0_q + CNT_W'(req0_ready);
      cnt1_d = cnt_clr ? '0 : cnt1_q + CNT_W'(req1_ready);
   end

   // counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed scoreboard bench for shift_arbiter
module tb_shift_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req1_a = '0;
   logic [4:0]  req0_shamt = '0, req1_shamt = '0;
   logic        req0_drxn = 1'b0, req1_drxn = 1'b0;
   logic        req0_type = 1'b0, req1_type = 1'b0;
   logic [3:0]  req0_tag = '0, req1_tag = '0;
   logic        res_valid, res_ready = 1'b1;
   logic [31:0] res_data;
   logic        res_port;
   logic [3:0]  res_tag;
   logic        busy;
`ifdef SHIFT_ARB_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [1:0]  gnt_cnt0, gnt_cnt1;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic        p;
      logic [3:0]  t;
   } exp_t;

   exp_t sb[$];
   int   acc_port[$];
   int   checks = 0;
   int   failures = 0;
   logic both_ready = 1'b0;

   always #5 clk = ~clk;

   shift_arbiter #(
`ifdef SHIFT_ARB_CNT_EN
      .CNT_W(2),
`endif
      .TAG_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_shamt(req0_shamt),
      .req0_drxn(req0_drxn), .req0_type(req0_type), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_shamt(req1_shamt),
      .req1_drxn(req1_drxn), .req1_type(req1_type), .req1_tag(req1_tag),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_port(res_port),
      .res_tag(res_tag),
`ifdef SHIFT_ARB_CNT_EN
      .busy(busy), .cnt_clr(cnt_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`else
      .busy(busy)
`endif
   );

   function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic d, input logic t);
      if (s == 5'd0) return a;
      if (!d) return t ? a : a << s;
      if (!t) return a >> s;
      return a[31] ? ~((~a) >> s) : a >> s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      exp_t e;
      #1;
      if (req0_valid && req0_ready) begin
         e.d = model(req0_a, req0_shamt, req0_drxn, req0_type); e.p = 1'b0; e.t = req0_tag;
         sb.push_back(e);
         acc_port.push_back(0);
      end
      if (req1_valid && req1_ready) begin
         e.d = model(req1_a, req1_shamt, req1_drxn, req1_type); e.p = 1'b1; e.t = req1_tag;
         sb.push_back(e);
         acc_port.push_back(1);
      end
      if (req0_ready && req1_ready) both_ready = 1'b1;
      if (res_valid && res_ready && rst_n) begin
         if (sb.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_data", res_data, e.d);
            chk("sb_port", 32'(res_port), 32'(e.p));
            chk("sb_tag", 32'(res_tag), 32'(e.t));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue0(input logic [31:0] a, input logic [4:0] s, input logic d, input logic t, input logic [3:0] g);
      req0_a = a; req0_shamt = s; req0_drxn = d; req0_type = t; req0_tag = g; req0_valid = 1'b1;
   endtask

   task automatic issue1(input logic [31:0] a, input logic [4:0] s, input logic d, input logic t, input logic [3:0] g);
      req1_a = a; req1_shamt = s; req1_drxn = d; req1_type = t; req1_tag = g; req1_valid = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 10 && !res_valid; k++) tick();
      chk(tag, 32'(res_valid), 32'd1);
   endtask

   task automatic drain;
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      tick(); tick();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_port", 32'(res_port), 32'd0);
      chk("rst_res_tag", 32'(res_tag), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef SHIFT_ARB_CNT_EN
      chk("rst_cnt0", 32'(gnt_cnt0), 32'd0);
`endif
      rst_n = 1'b1;
      // 1: logical left, latency accept+2
      issue0(32'h1, 5'd4, 1'b0, 1'b0, 4'h3);
      #1;
      chk("t1_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk("t1_valid_n1", 32'(res_valid), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_valid_n2", 32'(res_valid), 32'd1);
      chk("t1_data", res_data, 32'h10);
      chk("t1_port", 32'(res_port), 32'd0);
      tick();
      chk("t1_valid_drop", 32'(res_valid), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      // 2: arithmetic and logical right on port 1
      issue1(32'h8000_0000, 5'd31, 1'b1, 1'b1, 4'hA);
      tick();
      req1_valid = 1'b0;
      wait_valid("t2a_timeout");
      chk("t2a_data", res_data, 32'hFFFF_FFFF);
      chk("t2a_port", 32'(res_port), 32'd1);
      chk("t2a_tag", 32'(res_tag), 32'hA);
      drain();
      issue1(32'h8000_0000, 5'd31, 1'b1, 1'b0, 4'hA);
      tick();
      req1_valid = 1'b0;
      wait_valid("t2b_timeout");
      chk("t2b_data", res_data, 32'h1);
      drain();
      // 3: both ports valid from reset alternate grants
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      acc_port.delete();
      both_ready = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 40 && acc_port.size() < 6; k++) begin
         issue0($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'(k));
         issue1($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'(k + 8));
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();
      chk("t3_count", 32'(acc_port.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < acc_port.size()) chk("t3_order", 32'(acc_port[i]), 32'(i % 2));
      chk("t3_both_ready", 32'(both_ready), 32'd0);
      // 4: back-pressure holds result and blocks new grant
      res_ready = 1'b0;
      issue0(32'h0000_FFFF, 5'd16, 1'b0, 1'b0, 4'h5);
      tick();
      req0_a = 32'h1;
      wait_valid("t4_timeout");
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_hold_valid", 32'(res_valid), 32'd1);
         chk("t4_hold_data", res_data, 32'hFFFF_0000);
         chk("t4_hold_tag", 32'(res_tag), 32'h5);
         chk("t4_no_ready", 32'(req0_ready), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      chk("t4_idle", 32'(busy), 32'd0);
      chk("t4_ready_again", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      wait_valid("t4b_timeout");
      chk("t4b_data", res_data, 32'h0001_0000);
      drain();
      // 5: arithmetic left passes through; zero shift returns operand
      issue0(32'h1234_5678, 5'd8, 1'b0, 1'b1, 4'h1);
      tick();
      req0_valid = 1'b0;
      wait_valid("t5_timeout");
      chk("t5_arith_left", res_data, 32'h1234_5678);
      drain();
      for (int m = 0; m < 4; m++) begin
         issue0(32'hCAFE_0123 ^ 32'(m), 5'd0, m[0], m[1], 4'(m));
         tick();
         req0_valid = 1'b0;
         wait_valid("t5z_timeout");
         chk("t5_zero_shift", res_data, 32'hCAFE_0123 ^ 32'(m));
         drain();
      end
      // 6: reset during EXEC discards request and restores tie to port 0
      issue0(32'h0F, 5'd1, 1'b0, 1'b0, 4'h7);
      tick();
      req0_valid = 1'b0;
      chk("t6_in_exec", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", 32'(res_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      sb.delete();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("t6_no_result", 32'(res_valid), 32'd0);
      issue0(32'h3, 5'd2, 1'b0, 1'b0, 4'h2);
      issue1(32'h4, 5'd1, 1'b1, 1'b0, 4'h4);
      #1;
      chk("t6_tie_ready0", 32'(req0_ready), 32'd1);
      chk("t6_tie_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();
`ifdef SHIFT_ARB_CNT_EN
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clear0", 32'(gnt_cnt0), 32'd0);
      for (int k = 0; k < 5; k++) begin
         issue0(32'(k), 5'd1, 1'b0, 1'b0, 4'(k));
         tick();
         req0_valid = 1'b0;
         drain();
      end
      chk("cnt_wrap0", 32'(gnt_cnt0), 32'd1);
      chk("cnt_port1", 32'(gnt_cnt1), 32'd0);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clear1", 32'(gnt_cnt0), 32'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
